// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : arb_pkg                                                       |
// | Purpose  : Shared definitions for the round-robin resource arbiter:      |
// |            FSM state encoding and the hold-counter width helper.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package arb_pkg;

    // Arbiter FSM states; the encoding is fixed so it can be probed on a bus.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        START   = 2'b01,
        WAIT    = 2'b10,
        RELEASE = 2'b11
    } state_t;

    // The hold counter must represent 0..MAX_HOLD without wrapping.
    function automatic int hold_cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick_first.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick_first                                                 |
// | Purpose  : Combinational round-robin picker. Rotates the request vector  |
// |            so rr_ptr lands on bit 0, priority-encodes the lowest set     |
// |            bit, then rotates the index back into requester numbering.    |
// | Ports    : req     in  N_REQ  request vector                             |
// |            rr_ptr  in  IDX_W  highest-priority requester index           |
// |            winner  out IDX_W  first requester at or after rr_ptr (wrap)  |
// |            any_req out 1      at least one request is set                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_pick_first #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_off;
    logic             w_found;

    always_comb begin
        int j;
        j       = 0;
        w_rot   = '0;
        w_off   = '0;
        w_found = 1'b0;

        // Rotate: w_rot[i] is the requester i positions after rr_ptr.
        for (int i = 0; i < N_REQ; i++) begin
            j        = (i + int'(rr_ptr)) % N_REQ;
            w_rot[i] = req[IDX_W'(j)];
        end

        // Priority-encode the lowest set bit of the rotated vector.
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDX_W'(i);
            end
        end

        // Unrotate back to an absolute requester index.
        j = int'(w_off) + int'(rr_ptr);
        if (j >= N_REQ) begin
            j = j - N_REQ;
        end
        winner  = IDX_W'(j);
        any_req = |req;
    end

endmodule : rr_pick_first
`default_nettype wire

// File: rtl/rr_resource_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_resource_arbiter                                           |
// | Purpose  : Shares one multi-cycle resource among N_REQ requesters. Picks |
// |            an owner round-robin, pulses res_start once, and holds the    |
// |            grant until res_done or a MAX_HOLD-cycle timeout.             |
// | Ports    : clk          in  1      rising-edge clock                     |
// |            rst          in  1      async active-high reset               |
// |            req          in  N_REQ  level requests                        |
// |            res_done     in  1      resource completion (WAIT only)       |
// |            grant        out N_REQ  one-hot grant, registered             |
// |            grant_idx    out IDX_W  current owner index, registered       |
// |            grant_valid  out 1      high in START and WAIT                |
// |            res_start    out 1      one-cycle start pulse (START)         |
// |            timeout_err  out 1      one-cycle pulse on forced release     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             res_done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             res_start,
    output logic             timeout_err
);

    localparam int             CNT_W       = hold_cnt_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_hold;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_owner;
    logic             w_any;
    logic             w_timeout;
    logic             w_own_next;
    logic [N_REQ-1:0] w_grant_next;

    rr_pick_first #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_pick),
        .any_req (w_any)
    );

    // Next-state logic. A res_done outside WAIT is deliberately ignored, and
    // done takes precedence over a timeout landing in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:    if (w_any) w_next = START;
            START:   w_next = WAIT;
            WAIT: begin
                if (res_done) begin
                    w_next = RELEASE;
                end else if (r_hold == c_hold_last) begin
                    w_next    = RELEASE;
                    w_timeout = 1'b1;
                end
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The owner is taken straight from the picker on the IDLE->START edge so
    // the grant appears in the same cycle as res_start; afterwards the
    // latched index is used and later req changes have no effect.
    always_comb begin
        w_owner      = (r_state == IDLE) ? w_pick : grant_idx;
        w_own_next   = (w_next == START) || (w_next == WAIT);
        w_grant_next = w_own_next ? (N_REQ'(1) << w_owner) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from w_next so they line up with the state
    // they describe rather than lagging it by a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            res_start   <= 1'b0;
            timeout_err <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            grant       <= w_grant_next;
            grant_valid <= w_own_next;
            res_start   <= (w_next == START);
            timeout_err <= w_timeout;
            if (r_state == IDLE && w_next == START) begin
                grant_idx <= w_pick;
            end
            if (w_next == RELEASE) begin
                r_rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Counts WAIT cycles; zero outside WAIT. Leaves WAIT at MAX_HOLD-1 at
    // the latest, so the counter never reaches its wrap point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == WAIT && w_next == WAIT) begin
            r_hold <= r_hold + 1'b1;
        end else begin
            r_hold <= '0;
        end
    end

endmodule : rr_resource_arbiter
`default_nettype wire

// File: tb/tb_rr_resource_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rr_resource_arbiter                                        |
// | Purpose  : Self-checking bench for rr_resource_arbiter. Expected owners  |
// |            are queued when requests are driven and compared when the     |
// |            DUT issues res_start.                                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rr_resource_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       res_done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       res_start;
    logic       timeout_err;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int last_start = 0;
    int exp_q[$];

    rr_resource_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .res_done    (res_done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .res_start   (res_start),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for res_start, pop the queued owner and compare.
    task automatic expect_start(input string tag, input int exp_gap);
        int n;
        int e;
        n = 0;
        while (res_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(res_start), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        if (res_start === 1'b1) begin
            chk({tag, "_grant_idx"}, 32'(grant_idx), 32'(e));
            chk({tag, "_grant"}, 32'(grant), 32'd1 << e);
            chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd1);
            if (exp_gap > 0) begin
                chk({tag, "_start_gap"}, 32'(cyc - last_start), 32'(exp_gap));
            end
            last_start = cyc;
        end
    endtask

    // Called at the START negedge: drive res_done in the dly-th WAIT cycle,
    // then check the RELEASE cycle.
    task automatic serve(input string tag, input int dly);
        @(negedge clk);
        chk({tag, "_start_one_cycle"}, 32'(res_start), 32'd0);
        chk({tag, "_wait_valid"}, 32'(grant_valid), 32'd1);
        repeat (dly - 1) @(negedge clk);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        chk({tag, "_rel_grant"}, 32'(grant), 32'd0);
        chk({tag, "_rel_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_rel_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int v;
        rst      = 1'b1;
        req      = 4'b0000;
        res_done = 1'b0;

        // Reset held with all requests active: nothing may be issued.
        repeat (2) @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_res_start", 32'(res_start), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);

        exp_q.push_back(0);
        rst = 1'b0;
        expect_start("t1", 0);
        serve("t1", 3);

        // Round robin with all requesting: 1,2,3,0 with 6-cycle spacing.
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(k % 4);
            expect_start("t2", 6);
            serve("t2", 3);
        end

        // Skip non-requesters and wrap: ptr=1 -> 2, ptr=3 -> 0, ptr=1 -> 2.
        req = 4'b0101;
        exp_q.push_back(2);
        expect_start("t3a", 6);
        serve("t3a", 3);
        exp_q.push_back(0);
        expect_start("t3b", 6);
        serve("t3b", 3);
        exp_q.push_back(2);
        expect_start("t3c", 6);
        serve("t3c", 3);

        // Timeout on requester 1 (ptr=3 scans 3,0,1).
        req = 4'b0010;
        exp_q.push_back(1);
        expect_start("t4", 6);
        v = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (grant_valid === 1'b1 && timeout_err === 1'b0) v++;
        end
        chk("t4_wait_cycles", 32'(v), 32'd16);
        @(negedge clk);
        chk("t4_timeout_pulse", 32'(timeout_err), 32'd1);
        chk("t4_rel_grant", 32'(grant), 32'd0);
        chk("t4_rel_valid", 32'(grant_valid), 32'd0);
        req = 4'b1111;
        exp_q.push_back(2);
        @(negedge clk);
        chk("t4_timeout_one_cycle", 32'(timeout_err), 32'd0);
        expect_start("t4_ptr", 0);

        // Done on the last WAIT cycle wins over the timeout.
        serve("t5a", 16);

        // Done during START is ignored.
        exp_q.push_back(3);
        expect_start("t5b", 0);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        chk("t5b_still_valid", 32'(grant_valid), 32'd1);
        chk("t5b_still_grant", 32'(grant), 32'h8);
        @(negedge clk);
        chk("t5b_still_wait", 32'(grant_valid), 32'd1);
        res_done = 1'b1;
        @(negedge clk);
        res_done = 1'b0;
        chk("t5b_rel_grant", 32'(grant), 32'd0);

        // Asynchronous reset while requester 2 owns the resource.
        req = 4'b0100;
        exp_q.push_back(2);
        expect_start("t6", 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'd0);
        chk("t6_async_valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        chk("t6_rst_no_start_a", 32'(res_start), 32'd0);
        @(negedge clk);
        chk("t6_rst_no_start_b", 32'(res_start), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        exp_q.push_back(2);
        expect_start("t6_after", 0);
        serve("t6_after", 3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_resource_arbiter
`default_nettype wire
